// File: rtl/input_loader_pkg.sv
// Shared types for the puzzle-loading path: RAM address type, loader FSM states, ASCII codes.
package AocPkg;
  localparam int RAM_ADDR_W = 15;
  typedef logic [RAM_ADDR_W-1:0] RamAddr_t;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    DONE = 2'd1,
    ERR  = 2'd2
  } LoaderState_t;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;
endpackage

// File: rtl/input_loader.sv
// Streams the puzzle bytes into ByteRam, measuring row geometry and flagging malformed input.
module input_loader
  import AocPkg::*;
#(
  parameter int ADDR_W = $bits(RamAddr_t),
  parameter int COL_W  = 8,
  parameter int ROW_W  = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              InValid,
  output logic              InReady,
  input  logic [7:0]        InData,
  input  logic              InLast,
  output logic [ADDR_W-1:0] WriteAddr,
  output logic              WriteEnable,
  output logic [7:0]        WriteData,
  output logic              LoadDone,
  output logic              Error,
  output logic [ADDR_W:0]   ByteCount,
  output logic [COL_W-1:0]  RowWidth,
  output logic [ROW_W-1:0]  RowCount
);
  LoaderState_t     state;
  logic [COL_W-1:0] col;
  logic             width_set;

  logic             accept, is_lf, is_cr, wr_byte, close_row;
  logic [COL_W-1:0] col_inc, row_len;
  logic             err_ovf, err_blank, err_wide, err_ragged, err;

  assign InReady = (state == LOAD);
  assign accept  = InValid & InReady;
  assign is_lf   = (InData == ASCII_LF);
  assign is_cr   = (InData == ASCII_CR);
  assign wr_byte = accept & ~is_cr;
  assign col_inc = col + 1'b1;

  // Length of the row this byte would close: LF/CR add no cell, anything else adds one.
  assign row_len   = (is_lf | is_cr) ? col : col_inc;
  assign close_row = is_lf | (InLast & (row_len != '0));

  // ByteCount never exceeds 2**ADDR_W, so its MSB alone means "RAM full".
  assign err_ovf    = wr_byte & ByteCount[ADDR_W];
  assign err_blank  = is_lf & (col == '0);
  assign err_wide   = ~is_lf & ~is_cr & (&col);
  assign err_ragged = close_row & width_set & (row_len != RowWidth);
  assign err        = accept & (err_ovf | err_blank | err_wide | err_ragged);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= LOAD;
      col         <= '0;
      width_set   <= 1'b0;
      WriteAddr   <= '0;
      WriteEnable <= 1'b0;
      WriteData   <= '0;
      LoadDone    <= 1'b0;
      Error       <= 1'b0;
      ByteCount   <= '0;
      RowWidth    <= '0;
      RowCount    <= '0;
    end else begin
      WriteEnable <= 1'b0;
      if (err) begin
        Error <= 1'b1;
        state <= ERR;
      end else if (accept) begin
        if (wr_byte) begin
          WriteEnable <= 1'b1;
          WriteAddr   <= ByteCount[ADDR_W-1:0];
          WriteData   <= InData;
          ByteCount   <= ByteCount + 1'b1;
        end
        if (close_row) begin
          col      <= '0;
          RowCount <= RowCount + 1'b1;
          if (!width_set) begin
            RowWidth  <= row_len;
            width_set <= 1'b1;
          end
        end else if (!is_cr) begin
          col <= col_inc;
        end
        if (InLast) begin
          LoadDone <= 1'b1;
          state    <= DONE;
        end
      end
    end
  end
endmodule
